// File: rtl/sram_readout_if.sv
// Bundle between the readout engine, the dual-port histogram SRAM and the downstream consumer.
// Stream handshake: a word moves when m_valid & m_ready; once m_valid rises, m_data/m_addr/m_last stay stable and m_valid stays high until accepted.
interface sram_readout_if #(
    parameter int DW = 21,
    parameter int AW = 6
);
    logic          meb;
    logic [AW-1:0] adrb;
    logic [DW-1:0] qb;
    logic          mea;
    logic          wea;
    logic [AW-1:0] adra;
    logic [DW-1:0] da;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic          m_last;

    modport master (
        output meb, adrb, mea, wea, adra, da, m_valid, m_data, m_addr, m_last,
        input  qb, m_ready
    );

    modport slave (
        input  meb, adrb, mea, wea, adra, da, m_valid, m_data, m_addr, m_last,
        output qb, m_ready
    );
endinterface

// File: rtl/sram_readout.sv
// Sweeps all SRAM addresses through port B, streams each word with its address through a
// 2-entry FIFO, and optionally zeroes each entry through port A in the cycle it is captured.
module sram_readout #(
    parameter int DW = 21,
    parameter int AW = 6
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_clear_en,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_state,
    sram_readout_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        r_state;
    state_t        w_next;
    logic          r_clr;
    logic          r_done;
    logic          r_inflight;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_adrb;
    logic [DW-1:0] r_fdata [2];
    logic [AW-1:0] r_faddr [2];
    logic          r_wsel;
    logic          r_rsel;
    logic [1:0]    r_count;

    logic          w_issue;
    logic          w_pop;
    logic          w_push;
    logic          w_last;
    logic [2:0]    w_pending;

    // A new read is only issued if its word is guaranteed a FIFO slot on arrival.
    always_comb begin
        w_pop     = (r_count != 2'd0) && bus.m_ready;
        w_push    = r_inflight;
        w_pending = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue   = (r_state == RUN) && (w_pending < 3'd2);
        w_last    = (r_count != 2'd0) && (r_faddr[r_rsel] == LAST_ADDR);
        w_next    = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = RUN;
            RUN:     if (w_issue && (r_ptr == LAST_ADDR)) w_next = DRAIN;
            DRAIN:   if (w_pop && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_clr      <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_ptr      <= '0;
            r_adrb     <= '0;
            r_fdata[0] <= '0;
            r_fdata[1] <= '0;
            r_faddr[0] <= '0;
            r_faddr[1] <= '0;
            r_wsel     <= 1'b0;
            r_rsel     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_state    <= w_next;
            r_done     <= (r_state == DRAIN) && (w_next == IDLE);
            r_inflight <= w_issue;
            if ((r_state == IDLE) && i_start) begin
                r_clr <= i_clear_en;
                r_ptr <= '0;
            end else if (w_issue) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_issue) r_adrb <= r_ptr;
            if (w_push) begin
                r_fdata[r_wsel] <= bus.qb;
                r_faddr[r_wsel] <= r_adrb;
                r_wsel          <= ~r_wsel;
            end
            if (w_pop) r_rsel <= ~r_rsel;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // r_adrb still holds the address being captured, so it doubles as the clear address.
    assign bus.meb     = w_issue;
    assign bus.adrb    = w_issue ? r_ptr : r_adrb;
    assign bus.mea     = r_inflight & r_clr;
    assign bus.wea     = r_inflight & r_clr;
    assign bus.adra    = r_adrb;
    assign bus.da      = '0;
    assign bus.m_valid = (r_count != 2'd0);
    assign bus.m_data  = r_fdata[r_rsel];
    assign bus.m_addr  = r_faddr[r_rsel];
    assign bus.m_last  = w_last;

    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;
    assign o_state = r_state;
endmodule

// File: tb/tb_sram_readout.sv
// Bench for sram_readout: behavioural SRAM, expected-word queue built from memory rules, per-scenario tasks.
`timescale 1ns/1ps
module tb_sram_readout;
    localparam int DW = 21;
    localparam int AW = 6;
    localparam int N  = 64;
    localparam logic [AW-1:0] LAST = '1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clear_en;
    logic       busy;
    logic       done;
    logic [1:0] state;
    logic       preload_req = 1'b0;

    sram_readout_if #(.DW(DW), .AW(AW)) bus ();

    sram_readout #(.DW(DW), .AW(AW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_clear_en (clear_en),
        .o_busy     (busy),
        .o_done     (done),
        .o_state    (state),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] exp_mem [N];
    logic [AW+DW-1:0] exp_q [$];

    // Dual-port SRAM: registered read on B, write on A.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int a = 0; a < N; a++) mem[a] <= DW'(a * 1000);
        end else begin
            if (bus.meb) bus.qb <= mem[bus.adrb];
            if (bus.mea && bus.wea) mem[bus.adra] <= bus.da;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int r_first, r_last, r_done_cyc, r_done_n, r_got, r_mea_n;

    task automatic preload();
        preload_req = 1'b1;
        @(posedge clk); #1;
        preload_req = 1'b0;
        for (int a = 0; a < N; a++) exp_mem[a] = DW'(a * 1000);
    endtask

    task automatic run_sweep(input bit clr, input int pct, input int st_s, input int st_len,
                             input int rp1, input int rp2, input int abort_at);
        int cyc, issued, accepted;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        logic [AW+DW-1:0] e;
        logic [AW-1:0] e_addr;
        exp_q.delete();
        for (int a = 0; a < N; a++) exp_q.push_back({AW'(a), exp_mem[a]});
        cyc = 0; issued = 0; accepted = 0; prev_stall = 0;
        prev_data = '0; prev_addr = '0;
        r_first = -1; r_last = -1; r_done_cyc = -1; r_done_n = 0; r_got = 0; r_mea_n = 0;
        while (1) begin
            start    = (cyc == 0) || (cyc == rp1) || (cyc == rp2);
            clear_en = (cyc == 0) ? clr : ~clr;
            rst_n    = (cyc != abort_at);
            bus.m_ready = (cyc >= st_s && cyc < st_s + st_len) ? 1'b0 :
                          (int'($urandom_range(0, 99)) < pct);
            #1;
            if (prev_stall) begin
                n_checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_addr !== prev_addr) begin
                    n_errors++;
                    $display("FAIL stable cyc=%0d: got v=%b addr=%0d data=%0d, need v=1 addr=%0d data=%0d",
                             cyc, bus.m_valid, bus.m_addr, bus.m_data, prev_addr, prev_data);
                end
            end
            if (bus.meb === 1'b1) issued++;
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                accepted++;
                r_got++;
                if (r_first < 0) r_first = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_word cyc=%0d: got addr=%0d, need none", cyc, bus.m_addr);
                end else begin
                    e = exp_q.pop_front();
                    e_addr = e[AW+DW-1:DW];
                    if (e_addr == LAST) r_last = cyc;
                    if (bus.m_addr !== e_addr || bus.m_data !== e[DW-1:0] || bus.m_last !== (e_addr == LAST)) begin
                        n_errors++;
                        $display("FAIL word cyc=%0d: got addr=%0d data=%0d last=%b, need addr=%0d data=%0d last=%b",
                                 cyc, bus.m_addr, bus.m_data, bus.m_last, e_addr, e[DW-1:0], (e_addr == LAST));
                    end
                end
            end
            n_checks++;
            if (issued - accepted > 2) begin
                n_errors++;
                $display("FAIL outstanding cyc=%0d: got %0d, need <=2", cyc, issued - accepted);
            end
            if (bus.mea === 1'b1 || bus.wea === 1'b1) begin
                r_mea_n++;
                n_checks++;
                if (!clr || bus.mea !== 1'b1 || bus.wea !== 1'b1 || bus.da !== '0 ||
                    (bus.meb === 1'b1 && bus.adrb === bus.adra)) begin
                    n_errors++;
                    $display("FAIL clear_write cyc=%0d: got mea=%b wea=%b da=%0d adra=%0d, need clr=%0b mea=wea=1 da=0",
                             cyc, bus.mea, bus.wea, bus.da, bus.adra, clr);
                end
            end
            if (done === 1'b1) begin
                r_done_n++;
                r_done_cyc = cyc;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL busy_at_done cyc=%0d: got busy=%b, need 0", cyc, busy);
                end
            end
            prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
            prev_data  = bus.m_data;
            prev_addr  = bus.m_addr;
            @(posedge clk); #1;
            if (cyc == abort_at) break;
            cyc++;
            if (r_done_n > 0 && cyc > r_done_cyc + 3) break;
            if (cyc > 400) begin
                n_checks++;
                n_errors++;
                $display("FAIL timeout: got no done within 400 cycles, need done");
                break;
            end
        end
        start = 1'b0; clear_en = 1'b0; rst_n = 1'b1; bus.m_ready = 1'b1;
    endtask

    task automatic check_timing(input string name, input int first, input int last, input int dcyc);
        n_checks++;
        if (r_got != N || r_first != first || r_last != last || r_done_cyc != dcyc || r_done_n != 1) begin
            n_errors++;
            $display("FAIL %s_timing: got words=%0d first=%0d last=%0d done=%0d ndone=%0d, need %0d/%0d/%0d/%0d/1",
                     name, r_got, r_first, r_last, r_done_cyc, r_done_n, N, first, last, dcyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clear_en = 1'b0; bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, bus.meb, bus.mea, bus.wea, bus.m_valid, bus.m_last} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b, need 0000000",
                     {busy, done, bus.meb, bus.mea, bus.wea, bus.m_valid, bus.m_last});
        end
        n_checks++;
        if ({bus.adrb, bus.adra, bus.m_addr} !== '0 || {bus.da, bus.m_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_bus: got adrb=%0d adra=%0d m_addr=%0d da=%0d m_data=%0d, need all 0",
                     bus.adrb, bus.adra, bus.m_addr, bus.da, bus.m_data);
        end
        rst_n = 1'b1; bus.m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_plain();
        preload();
        run_sweep(1'b0, 100, -1, 0, -1, -1, -1);
        check_timing("plain", 3, 66, 67);
        n_checks++;
        if (r_mea_n != 0) begin
            n_errors++;
            $display("FAIL plain_no_clear: got %0d write cycles, need 0", r_mea_n);
        end
    endtask

    task automatic test_clear();
        preload();
        run_sweep(1'b1, 100, -1, 0, -1, -1, -1);
        check_timing("clear", 3, 66, 67);
        n_checks++;
        if (r_mea_n != N) begin
            n_errors++;
            $display("FAIL clear_count: got %0d write cycles, need %0d", r_mea_n, N);
        end
        for (int a = 0; a < N; a++) exp_mem[a] = '0;
        run_sweep(1'b0, 100, -1, 0, -1, -1, -1);
        check_timing("zeros", 3, 66, 67);
    endtask

    task automatic test_random_ready();
        preload();
        run_sweep(1'b0, 30, -1, 0, -1, -1, -1);
        check_timing("random", r_first, r_last, r_last + 1);
        n_checks++;
        if (r_first < 3 || r_last < 66) begin
            n_errors++;
            $display("FAIL random_bounds: got first=%0d last=%0d, need first>=3 last>=66", r_first, r_last);
        end
    endtask

    task automatic test_stall();
        preload();
        run_sweep(1'b0, 100, 5, 20, -1, -1, -1);
        check_timing("stall", 3, 86, 87);
    endtask

    task automatic test_restart();
        preload();
        run_sweep(1'b0, 100, -1, 0, 10, 40, -1);
        check_timing("restart", 3, 66, 67);
        n_checks++;
        if (r_mea_n != 0) begin
            n_errors++;
            $display("FAIL restart_clear: got %0d write cycles, need 0", r_mea_n);
        end
    endtask

    task automatic test_abort();
        preload();
        run_sweep(1'b1, 100, -1, 0, -1, -1, 20);
        #1;
        n_checks++;
        if ({busy, done, bus.meb, bus.mea, bus.wea, bus.m_valid, bus.m_last} !== 7'b0 ||
            {bus.adrb, bus.adra, bus.m_addr} !== '0 || {bus.da, bus.m_data} !== '0) begin
            n_errors++;
            $display("FAIL abort_outputs: got ctrl=%b adrb=%0d adra=%0d m_addr=%0d m_data=%0d, need all 0",
                     {busy, done, bus.meb, bus.mea, bus.wea, bus.m_valid, bus.m_last},
                     bus.adrb, bus.adra, bus.m_addr, bus.m_data);
        end
        @(posedge clk); #1;
        // Captures in cycles 2..20 cleared addresses 0..18 before reset took effect.
        for (int a = 0; a < N; a++) exp_mem[a] = (a < 19) ? '0 : DW'(a * 1000);
        run_sweep(1'b0, 100, -1, 0, -1, -1, -1);
        check_timing("after_abort", 3, 66, 67);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_plain();
        test_clear();
        test_random_ready();
        test_stall();
        test_restart();
        test_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_readout.md
# sram_readout

Read-side engine for the 64×21 dual-port histogram SRAM. On a start pulse it sweeps every address through read port B, absorbs the one-cycle SRAM read latency, and streams each word out on a valid/ready interface tagged with its address. Optionally it clears each entry to zero through write port A right after reading it, so the next acquisition starts from an empty memory. It sits between the SRAM macro and the downstream histogram consumer, such as a peak finder or host readout.

## Interface
- DW, 21, SRAM word width
- AW, 6, SRAM address width; sweep length is 2^AW = 64 words
- clk  in  1  single clock; also drives the SRAM CLKA/CLKB
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
- clear_en  in  1  sampled together with start; 1 = zero each entry after reading it
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when the sweep completes
- meb  out  1  SRAM port B memory enable (MEB)
- adrb  out  AW  SRAM port B address (ADRB)
- qb  in  DW  SRAM port B read data (QB), valid the cycle after meb
- mea  out  1  SRAM port A memory enable (MEA)
- wea  out  1  SRAM port A write enable (WEA)
- adra  out  AW  SRAM port A address (ADRA)
- da  out  DW  SRAM port A write data (DA); always zero
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts the word
- m_data  out  DW  output word
- m_addr  out  AW  SRAM address the word was read from
- m_last  out  1  high with the word from address 2^AW−1

## Operation
- **States:** IDLE, RUN, DRAIN.
  - IDLE → RUN when start=1. On that transition, clear_en is latched, the read pointer is set to 0 and busy is set.
  - RUN issues reads. RUN → DRAIN in the cycle the read of address 63 is issued.
  - DRAIN → IDLE in the cycle the m_last word is accepted (m_valid & m_ready & m_last). done pulses in the following cycle, and busy drops in that same cycle.
- **Read issue:**
  - In RUN, drive meb=1 with adrb=pointer only when (FIFO occupancy + reads in flight − pop this cycle) < 2.
  - The pointer increments on each issued read.
  - When no read is issued, meb=0 and adrb holds its last value.
- **Capture:**
  - The cycle after meb=1, qb and the registered address are written into a 2-entry output FIFO.
  - The FIFO head drives m_data, m_addr and m_last. m_valid = FIFO not empty.
- **Handshake:**
  - A word is transferred when m_valid & m_ready.
  - m_data, m_addr and m_last must stay stable while m_valid=1 and m_ready=0.
  - m_valid must not drop until the word is accepted.
- **Clear:**
  - Applies when the latched clear_en=1.
  - In the capture cycle, drive mea=1, wea=1, adra=captured address, da=0.
  - A clear write never targets the address being read in the same cycle.
  - When clear_en=0, mea and wea stay 0 for the whole sweep.
- **Start handling:** start asserted while busy=1 is ignored and has no effect on the sweep.
- **Reset:**
  - Reset has priority over everything, including mid-sweep.
  - Next cycle: state IDLE, FIFO empty, pointer 0, no reads in flight.
  - The SRAM contents are left as they are; a partial clear is not undone.
- **Reset values:** busy, done, meb, mea, wea, m_valid and m_last = 0; adrb, adra, da, m_data and m_addr = 0.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Cycle 1: busy=1, meb=1, adrb=0.
- Cycle 2: qb holds word 0 and is captured. If clearing, mea=wea=1 and adra=0.
- Cycle 3: m_valid=1, m_addr=0.
- With m_ready held high:
  - one word transfers per cycle;
  - words transfer in cycles 3..66, with m_last=1 in cycle 66;
  - done=1 and busy=0 in cycle 67;
  - a new start is accepted from cycle 67 onward.
- Backpressure:
  - Each cycle with m_ready=0 while m_valid=1 delays all later events by one cycle.
  - At most 2 words are buffered plus in flight, so no qb data is ever lost.
- Latency from start to first m_valid is fixed at 3 cycles.
- Each word is read exactly once, in address order 0..63.

## Test plan
- Preload SRAM with word[a] = a·1000, m_ready=1, clear_en=0. Start → 64 words with m_data=a·1000 and m_addr=a, in cycles 3..66; m_last only on address 63; done in cycle 67; mea and wea never assert.
- Same preload with clear_en=1. Start → identical output stream; a second sweep then returns 64 zeros.
- Random m_ready at 30% duty → all 64 words delivered in order with no duplicates or drops; outputs stay stable while m_valid=1 and m_ready=0; meb outstanding never exceeds the 2-slot limit.
- m_ready=0 for 20 cycles starting at cycle 5 → m_valid held with m_addr fixed; at most 2 reads issued past the stalled word; the stream resumes correctly.
- start re-pulsed in cycles 10 and 40 → ignored; exactly one done.
- rst_n=0 in cycle 20 of a clearing sweep → next cycle all outputs are 0 and state is IDLE; a fresh start runs a full, correct sweep (entries already cleared read 0, the rest keep their preload values).
